// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module : alu_pkg
// Brief  : ALU op codes, R-type funct and field constants, sequencer states.
// Rev    : 1.0 - initial release
//==============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd6;
    localparam logic [3:0] ALU_GT  = 4'd7;
    localparam logic [3:0] ALU_LT  = 4'd8;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_SGT = 6'h2C;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        ERR  = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rtype_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module : rtype_sequencer_if
// Brief  : Instruction handshake, regfile and ALU signals of the sequencer.
// Rev    : 1.0 - initial release
//==============================================================================
interface rtype_sequencer_if;

    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    logic [4:0]  rf_rr1;
    logic [4:0]  rf_rr2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [4:0]  rf_wr;
    logic        rf_we;
    logic        rf_sel;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_overflow;

    logic        done;
    logic        err_ovf;
    logic        err_illegal;

    // master = the sequencer (initiator of regfile/ALU control)
    modport master (
        input  instr, instr_valid, rf_rd1, rf_rd2, alu_result, alu_overflow,
        output instr_ready, rf_rr1, rf_rr2, rf_wr, rf_we, rf_sel,
               alu_a, alu_b, alu_op, alu_shamt, done, err_ovf, err_illegal
    );

    modport slave (
        output instr, instr_valid, rf_rd1, rf_rd2, alu_result, alu_overflow,
        input  instr_ready, rf_rr1, rf_rr2, rf_wr, rf_we, rf_sel,
               alu_a, alu_b, alu_op, alu_shamt, done, err_ovf, err_illegal
    );

endinterface
`default_nettype wire

// File: rtl/rtype_decoder.sv
`default_nettype none
//==============================================================================
// Module : rtype_decoder
// Brief  : Combinational MIPS R-type decode to ALU op, fields and legality.
// Rev    : 1.0 - initial release
//==============================================================================
module rtype_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic        illegal,
    output logic [3:0]  alu_op,
    output logic        is_shift,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unmapped;

    assign w_opcode = instr[OPCODE_HI:OPCODE_LO];
    assign w_funct  = instr[FUNCT_HI:FUNCT_LO];
    assign rs       = instr[RS_HI:RS_LO];
    assign rt       = instr[RT_HI:RT_LO];
    assign rd       = instr[RD_HI:RD_LO];
    assign shamt    = instr[SHAMT_HI:SHAMT_LO];

    always_comb begin
        alu_op     = ALU_ADD;
        is_shift   = 1'b0;
        w_unmapped = 1'b0;
        case (w_funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_SLL: begin alu_op = ALU_SLL; is_shift = 1'b1; end
            FUNCT_SRL: begin alu_op = ALU_SRL; is_shift = 1'b1; end
            FUNCT_SRA: begin alu_op = ALU_SRA; is_shift = 1'b1; end
            FUNCT_SGT: alu_op = ALU_GT;
            FUNCT_SLT: alu_op = ALU_LT;
            default:   w_unmapped = 1'b1;
        endcase
    end

    assign illegal = (w_opcode != 6'd0) || w_unmapped;

endmodule
`default_nettype wire

// File: rtl/rtype_sequencer.sv
`default_nettype none
//==============================================================================
// Module : rtype_sequencer
// Brief  : Multi-cycle R-type issue controller: READ -> EXEC -> WB sequencing.
// Rev    : 1.0 - initial release
//==============================================================================
module rtype_sequencer
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rtype_sequencer_if.master bus,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic        w_illegal;
    logic        w_is_shift;
    logic [3:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic        w_accept;
    logic        w_ovf;

    seq_state_t        r_state;
    logic              r_instr_ready;
    logic [4:0]        r_rf_rr1;
    logic [4:0]        r_rf_rr2;
    logic [4:0]        r_rf_wr;
    logic              r_rf_we;
    logic              r_rf_sel;
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [3:0]        r_alu_op;
    logic [4:0]        r_alu_shamt;
    logic              r_done;
    logic              r_err_ovf;
    logic              r_err_illegal;
    logic [CNT_W-1:0]  r_retired_cnt;

    rtype_decoder u_decoder (
        .instr    (bus.instr),
        .illegal  (w_illegal),
        .alu_op   (w_op),
        .is_shift (w_is_shift),
        .rs       (w_rs),
        .rt       (w_rt),
        .rd       (w_rd),
        .shamt    (w_shamt)
    );

    assign w_accept = bus.instr_valid && r_instr_ready;

    // The ALU overflow line is only meaningful for add/sub
    assign w_ovf = bus.alu_overflow && ((r_alu_op == ALU_ADD) || (r_alu_op == ALU_SUB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_instr_ready <= 1'b1;
            r_rf_rr1      <= 5'd0;
            r_rf_rr2      <= 5'd0;
            r_rf_wr       <= 5'd0;
            r_rf_we       <= 1'b0;
            r_rf_sel      <= 1'b0;
            r_alu_a       <= 32'd0;
            r_alu_b       <= 32'd0;
            r_alu_op      <= ALU_ADD;
            r_alu_shamt   <= 5'd0;
            r_done        <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_err_illegal <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            r_done        <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_err_illegal <= 1'b0;
            r_rf_we       <= 1'b0;
            r_rf_sel      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_instr_ready <= 1'b0;
                        r_rf_wr       <= w_rd;
                        r_alu_op      <= w_op;
                        r_alu_shamt   <= w_is_shift ? w_shamt : 5'd0;
                        r_rf_rr1      <= w_is_shift ? w_rt : w_rs;
                        r_rf_rr2      <= w_rt;
                        if (w_illegal) begin
                            r_state       <= ERR;
                            r_done        <= 1'b1;
                            r_err_illegal <= 1'b1;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    r_alu_a <= bus.rf_rd1;
                    r_alu_b <= bus.rf_rd2;
                    r_state <= EXEC;
                end
                EXEC: begin
                    // Operands stay held through WB, so alu_result still carries this result
                    r_state   <= WB;
                    r_done    <= 1'b1;
                    r_rf_sel  <= 1'b1;
                    r_err_ovf <= w_ovf;
                    r_rf_we   <= !w_ovf && (r_rf_wr != 5'd0);
                end
                WB: begin
                    r_state       <= IDLE;
                    r_instr_ready <= 1'b1;
                    if (!r_err_ovf) begin
                        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    r_state       <= IDLE;
                    r_instr_ready <= 1'b1;
                end
                default: begin
                    r_state       <= IDLE;
                    r_instr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.instr_ready = r_instr_ready;
    assign bus.rf_rr1      = r_rf_rr1;
    assign bus.rf_rr2      = r_rf_rr2;
    assign bus.rf_wr       = r_rf_wr;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_sel      = r_rf_sel;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_shamt   = r_alu_shamt;
    assign bus.done        = r_done;
    assign bus.err_ovf     = r_err_ovf;
    assign bus.err_illegal = r_err_illegal;
    assign retired_cnt     = r_retired_cnt;

endmodule
`default_nettype wire

// File: doc/rtype_sequencer.md
# rtype_sequencer

Multi-cycle issue controller that drives the existing ALU and 32x32 register file. It accepts MIPS R-type instruction words over a valid/ready handshake and decodes `funct` into the 4-bit ALU op. It then sequences the register-file read, the ALU execution and the write-back of the ALU result, and reports completion, overflow and illegal-instruction status. It sits on the initiator side of the regfile/ALU interface: it is the block that generates `rr1/rr2/wr/write_enable/selector/op/shift_amt`.

## Interface
- `CNT_W`, default 16, width of the retired-instruction counter.
- `clk`  in  1  system clock; rising edge active.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr`  in  32  R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `rf_rr1`, `rf_rr2`  out  5  regfile read addresses.
- `rf_rd1`, `rf_rd2`  in  32  regfile read data, combinational from the addresses.
- `rf_wr`  out  5  write address.
- `rf_we`  out  1  write enable.
- `rf_sel`  out  1  regfile write-data mux select; 1 selects ALU result.
- `alu_a`, `alu_b`  out  32  registered ALU operands.
- `alu_op`  out  4  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 gt, 8 lt.
- `alu_shamt`  out  5  shift amount.
- `alu_result`  in  32  ALU result, combinational.
- `alu_overflow`  in  1  ALU overflow, valid for ops 0 and 1 only.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `err_ovf`  out  1  qualifies `done`: add/sub overflowed, write suppressed.
- `err_illegal`  out  1  qualifies `done`: instruction is undecodable.
- `retired_cnt`  out  CNT_W  count of instructions that retired without error.

## Operation
- **funct map:**
  - 0x20→0, 0x22→1, 0x24→2, 0x25→3, 0x00→4, 0x02→5, 0x03→6, 0x2C→7 (sgt), 0x2A→8 (slt).
  - An instruction is illegal if opcode≠0 or `funct` is unmapped.
- **Operand routing:**
  - Non-shift ops: rr1=rs, rr2=rt.
  - Shifts (ops 4-6): rr1=rt, rr2=rt, and `alu_shamt`=shamt.
  - Non-shift ops: `alu_shamt`=0.
- **State machine (registered):**
  - IDLE: `instr_ready`=1. On valid&&ready, latch the decoded fields. Go to ERR if illegal, otherwise READ.
  - READ: drive rr1/rr2. At the clock edge, capture `rf_rd1`→`alu_a` and `rf_rd2`→`alu_b`. Go to EXEC.
  - EXEC: operands and `alu_op` are stable. At the clock edge, capture `alu_result` and `alu_overflow` (overflow masked to 0 for ops ≥2). Go to WB.
  - WB:
    - `done`=1 and `rf_sel`=1.
    - `rf_we`=1 unless rd==0 or the captured overflow is set.
    - `err_ovf` equals the captured overflow.
    - Go to IDLE.
  - ERR: `done`=1, `err_illegal`=1, `rf_we`=0. Go to IDLE.
- `rf_wr` holds the latched rd from acceptance until the next acceptance.
- **retired_cnt:** +1 on every `done` with no error, including writes to rd==0. Wraps modulo 2^CNT_W.
- **Write data:** the regfile writes the captured result (held on `alu_result` because the operands are still held), never a value from a new instruction.

## Timing
- **Reset values:** state IDLE; `instr_ready`=1. All of the following are 0: `rf_we`, `rf_sel`, `done`, `err_ovf`, `err_illegal`, `rf_rr1`, `rf_rr2`, `rf_wr`, `alu_a`, `alu_b`, `alu_op`, `alu_shamt`, `retired_cnt`.
- **Latency for a legal instruction:** accepted at edge 0. READ in cycle 1, EXEC in cycle 2, WB in cycle 3 (`rf_we`/`done` high), IDLE and ready again in cycle 4.
- **Throughput:** 1 instruction per 4 cycles.
- **Illegal instruction:** ERR in cycle 1, ready again in cycle 2.
- `instr_ready` is 0 in all states except IDLE. `instr_valid` held high while not ready is ignored, with no buffering. The producer must hold `instr` stable until the handshake.
- `rf_we`, `done` and the error flags are decoded only from registered state, so they are glitch-free.
- Reset asserted in any state: all outputs go to reset values asynchronously. The in-flight instruction is dropped and no write occurs.
- Reset deasserted: the block accepts its first instruction on the first edge on which `instr_valid` is seen while in IDLE.

## Structure
- **Shared package `alu_pkg`:**
  - ALU op constants (ADD…LT).
  - funct constants.
  - R-type field positions.
  - Sequencer state enum (IDLE, READ, EXEC, WB, ERR).
- **Sub-module `rtype_decoder`:** combinational. Maps `instr` to {illegal, alu_op, is_shift, rs, rt, rd, shamt}. It is reused by the future pipelined core.

## Test plan
- **add, rs=1, rt=2, rd=3:** rf_rd1=7, rf_rd2=5, alu_result=12 → cycle 1 rr1=1, rr2=2; cycle 2 alu_a=7, alu_b=5, op=0; cycle 3 rf_we=1, rf_wr=3, done=1; retired_cnt=1.
- **add with alu_overflow=1** (A=0x7FFFFFFF, B=5) → cycle 3 done=1, err_ovf=1, rf_we=0; retired_cnt unchanged.
- **sll rd=4, rt=2, shamt=5** → rr1=2, alu_op=4, alu_shamt=5; cycle 3 write to r4.
- **slt with rd=0** → done=1, rf_we=0, no error flags, retired_cnt+1.
- **Illegal words:** opcode 0x08, then funct 0x3F → cycle 1 done=1, err_illegal=1, rf_we=0; cycle 2 instr_ready=1.
- **Back-to-back and reset:**
  - instr_valid held high for 3 instructions → accepted on edges 0, 4 and 8.
  - rst_n pulsed low during EXEC → all outputs 0 at once, no rf_we pulse, instr_ready=1.
  - retired_cnt preloaded near 0xFFFF → wraps to 0.
